// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Counts rising edges of a single-bit spike train over fixed windows of
//   WINDOW_LEN clock cycles and presents one saturating rate sample per
//   window through a one-entry valid/ready holding register.
//
// Optional feature (macro SPIKE_RATE_THRESH_EN):
//   adds input `thresh` and output `out_class`; out_class is registered with
//   out_count and is 1 when the window's final count >= thresh (thresh is
//   sampled on the window's last cycle).
//
// Parameters:
//   WINDOW_LEN  window length in clock cycles (2..65535)
//   CNT_W       spike count width; count saturates at 2^CNT_W-1
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   spike_in   spike level from the neuron
//   enable     run/stop control for windowing
//   clr_ovr    clears the sticky overrun flag
//   out_count  spike count of the completed window
//   out_sat    the window's count saturated
//   out_valid  output sample pending
//   out_ready  consumer accepts the sample when out_valid & out_ready
//   overrun    sticky: a window result was dropped
//   busy       high while arming or counting
module spike_rate_decoder #(
  parameter int unsigned WINDOW_LEN = 16,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             enable,
  input  logic             clr_ovr,
`ifdef SPIKE_RATE_THRESH_EN
  input  logic [CNT_W-1:0] thresh,
  output logic             out_class,
`endif
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned WI_W = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [WI_W-1:0] WI_LAST = WI_W'(WINDOW_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]       r_state;
  logic             r_prev;
  logic [WI_W-1:0]  r_wi;
  logic [CNT_W-1:0] r_acc;
  logic             r_sat;

  logic [CNT_W-1:0] r_out_count;
  logic             r_out_sat;
  logic             r_out_valid;
  logic             r_overrun;
`ifdef SPIKE_RATE_THRESH_EN
  logic             r_out_class;
`endif

  logic             w_edge;
  logic             w_acc_max;
  logic [CNT_W-1:0] w_acc_next;
  logic             w_sat_next;
  logic             w_win_end;
  logic             w_load_ok;
  logic             w_drop;
  logic             w_consume;

  always_comb begin
    w_edge     = spike_in & ~r_prev;
    w_acc_max  = (r_acc == '1);
    w_acc_next = (w_edge && !w_acc_max) ? r_acc + CNT_W'(1) : r_acc;
    w_sat_next = r_sat | (w_edge & w_acc_max);
    // Dropping enable on the last window cycle abandons the window as well:
    // the stop request takes priority over producing a result.
    w_win_end  = (r_state == S_COUNT) && enable && (r_wi == WI_LAST);
    w_load_ok  = !r_out_valid || out_ready;
    w_drop     = w_win_end && !w_load_ok;
    w_consume  = r_out_valid && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prev      <= 1'b0;
      r_wi        <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef SPIKE_RATE_THRESH_EN
      r_out_class <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_ARM;
        end
        S_ARM: begin
          // Capturing the current level here keeps a spike that is already
          // high at start-up from being counted as an edge.
          r_prev  <= spike_in;
          r_wi    <= '0;
          r_acc   <= '0;
          r_sat   <= 1'b0;
          r_state <= enable ? S_COUNT : S_IDLE;
        end
        S_COUNT: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            r_prev <= spike_in;
            if (w_win_end) begin
              r_wi  <= '0;
              r_acc <= '0;
              r_sat <= 1'b0;
            end else begin
              r_wi  <= r_wi + WI_W'(1);
              r_acc <= w_acc_next;
              r_sat <= w_sat_next;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_win_end && w_load_ok) begin
        r_out_count <= w_acc_next;
        r_out_sat   <= w_sat_next;
        r_out_valid <= 1'b1;
`ifdef SPIKE_RATE_THRESH_EN
        r_out_class <= (w_acc_next >= thresh);
`endif
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);
`ifdef SPIKE_RATE_THRESH_EN
  assign out_class = r_out_class;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder
//   Two instances share all inputs: dut0 (WINDOW_LEN=16, CNT_W=4) and
//   dut1 (WINDOW_LEN=8, CNT_W=2, where saturation is reachable). A reference
//   model stores each window's raw spike samples and counts rising edges only
//   when the window completes; it is compared against both instances every
//   cycle, and directed sequences add hand-computed literal checks.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spike_in = 1'b0;
  logic       enable = 1'b0;
  logic       clr_ovr = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] th = 4'd0;

  logic [3:0] cnt0;
  logic [1:0] cnt1;
  logic       sat0, sat1, val0, val1, ovr0, ovr1, busy0, busy1;
`ifdef SPIKE_RATE_THRESH_EN
  logic       cls0, cls1;
  logic [1:0] th1;
  assign th1 = th[1:0];
`endif

  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW_LEN(16), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable),
    .clr_ovr(clr_ovr),
`ifdef SPIKE_RATE_THRESH_EN
    .thresh(th), .out_class(cls0),
`endif
    .out_count(cnt0), .out_sat(sat0), .out_valid(val0),
    .out_ready(out_ready), .overrun(ovr0), .busy(busy0)
  );

  spike_rate_decoder #(.WINDOW_LEN(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .spike_in(spike_in), .enable(enable),
    .clr_ovr(clr_ovr),
`ifdef SPIKE_RATE_THRESH_EN
    .thresh(th1), .out_class(cls1),
`endif
    .out_count(cnt1), .out_sat(sat1), .out_valid(val1),
    .out_ready(out_ready), .overrun(ovr1), .busy(busy1)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model, one slot per instance.
  int m_len [2] = '{16, 8};
  int m_max [2] = '{15, 3};
  bit m_run    [2];
  bit m_cnting [2];
  bit m_base   [2];
  bit m_win    [2][16];
  int m_n      [2];
  bit m_valid  [2];
  int m_cnt    [2];
  bit m_sat    [2];
  bit m_ovr    [2];
  bit m_cls    [2];

  task automatic chk(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit end_w;
      bit drop;
      int edges;
      bit p;
      int thk;
      end_w = 1'b0;
      drop  = 1'b0;
      edges = 0;
      if (rst) begin
        m_run[k] = 0; m_cnting[k] = 0; m_base[k] = 0; m_n[k] = 0;
        m_valid[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_ovr[k] = 0; m_cls[k] = 0;
      end else begin
        if (!m_run[k]) begin
          if (enable) begin
            m_run[k] = 1;
            m_cnting[k] = 0;
          end
        end else if (!m_cnting[k]) begin
          if (!enable) m_run[k] = 0;
          else begin
            m_base[k] = spike_in;
            m_n[k] = 0;
            m_cnting[k] = 1;
          end
        end else if (!enable) begin
          m_run[k] = 0;
        end else begin
          m_win[k][m_n[k]] = spike_in;
          m_n[k]++;
          if (m_n[k] == m_len[k]) begin
            p = m_base[k];
            for (int i = 0; i < m_len[k]; i++) begin
              if (m_win[k][i] && !p) edges++;
              p = m_win[k][i];
            end
            end_w = 1;
            m_n[k] = 0;
            m_base[k] = spike_in;
          end
        end

        if (end_w) begin
          if (!m_valid[k] || out_ready) begin
            m_valid[k] = 1;
            m_cnt[k] = (edges > m_max[k]) ? m_max[k] : edges;
            m_sat[k] = (edges > m_max[k]);
            thk = (k == 0) ? int'(th) : int'(th[1:0]);
            m_cls[k] = (m_cnt[k] >= thk);
          end else begin
            drop = 1;
            m_ovr[k] = 1;
          end
        end else if (m_valid[k] && out_ready) begin
          m_valid[k] = 0;
        end
        if (!drop && clr_ovr) m_ovr[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid",   0, int'(val0),  int'(m_valid[0]));
    chk("count",   0, int'(cnt0),  m_cnt[0]);
    chk("sat",     0, int'(sat0),  int'(m_sat[0]));
    chk("overrun", 0, int'(ovr0),  int'(m_ovr[0]));
    chk("busy",    0, int'(busy0), int'(m_run[0]));
    chk("valid",   1, int'(val1),  int'(m_valid[1]));
    chk("count",   1, int'(cnt1),  m_cnt[1]);
    chk("sat",     1, int'(sat1),  int'(m_sat[1]));
    chk("overrun", 1, int'(ovr1),  int'(m_ovr[1]));
    chk("busy",    1, int'(busy1), int'(m_run[1]));
`ifdef SPIKE_RATE_THRESH_EN
    chk("class",   0, int'(cls0),  int'(m_cls[0]));
    chk("class",   1, int'(cls1),  int'(m_cls[1]));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare.
  task automatic step(input bit rs, input bit en, input bit sp, input bit rdy, input bit clr);
    rst = rs; enable = en; spike_in = sp; out_ready = rdy; clr_ovr = clr;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("lit_rst_valid", 0, int'(val0), 0);
    chk("lit_rst_busy",  0, int'(busy0), 0);
    chk("lit_rst_ovr",   0, int'(ovr0), 0);
    chk("lit_rst_count", 0, int'(cnt0), 0);

    // Alternating spikes from the first counting cycle
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 1, (i % 2) == 0, 1, 0);
    chk("lit_toggle_count", 0, int'(cnt0), 8);
    chk("lit_toggle_valid", 0, int'(val0), 1);
    chk("lit_toggle_sat",   0, int'(sat0), 0);
    chk("lit_sat_count",    1, int'(cnt1), 3);
    chk("lit_sat_flag",     1, int'(sat1), 1);
    for (int i = 0; i < 16; i++) step(0, 1, (i % 2) == 0, 1, 0);
    chk("lit_toggle2_count", 0, int'(cnt0), 8);
    chk("lit_toggle2_valid", 0, int'(val0), 1);

    // Level already high at enable is masked
    step(0, 0, 1, 1, 0);
    chk("lit_stop_busy", 0, int'(busy0), 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 1, 0);
    chk("lit_high_count", 0, int'(cnt0), 0);
    chk("lit_high_valid", 0, int'(val0), 1);
    for (int i = 0; i < 16; i++) step(0, 1, (i == 2) || (i == 5) || (i == 9), 1, 0);
    chk("lit_three_count", 0, int'(cnt0), 3);

    // Hold, drop and overrun
    for (int i = 0; i < 16; i++) step(0, 1, (i % 4) == 1, i == 0, 0);
    chk("lit_hold_valid", 0, int'(val0), 1);
    chk("lit_hold_count", 0, int'(cnt0), 4);
    chk("lit_hold_ovr",   0, int'(ovr0), 0);
    for (int i = 0; i < 16; i++) step(0, 1, (i == 3) || (i == 7), 0, 0);
    chk("lit_drop_count", 0, int'(cnt0), 4);
    chk("lit_drop_ovr",   0, int'(ovr0), 1);
    step(0, 1, 0, 1, 0);
    chk("lit_consume_valid", 0, int'(val0), 0);
    chk("lit_consume_count", 0, int'(cnt0), 4);
    chk("lit_consume_ovr",   0, int'(ovr0), 1);
    step(0, 1, 0, 1, 1);
    chk("lit_clr_ovr", 0, int'(ovr0), 0);

    // Enable dropped mid-window
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, (i == 1) || (i == 3), 1, 0);
    step(0, 0, 0, 1, 0);
    chk("lit_abort_busy",  0, int'(busy0), 0);
    chk("lit_abort_valid", 0, int'(val0), 0);

    // Reset while a sample is pending
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, (i % 3) == 0, 0, 0);
    chk("lit_pend_valid", 0, int'(val0), 1);
    step(1, 1, 1, 0, 0);
    chk("lit_rst2_valid", 0, int'(val0), 0);
    chk("lit_rst2_count", 0, int'(cnt0), 0);
    chk("lit_rst2_sat",   0, int'(sat0), 0);
    chk("lit_rst2_busy",  0, int'(busy0), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      th = 4'($urandom_range(0, 15));
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 39) != 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
